// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single line-wide main-memory port between the I-cache (client 0)
// and the D-cache (client 1). One requester at a time is granted. Its
// rw/addr/wdata are latched and forwarded to memory. The result goes back to
// that requester only, as a one-cycle ready pulse with the read line. A
// watchdog aborts a transfer that memory never completes. An aborted transfer
// returns ready with rdata=0 and pulses err.
//
// Compile-time option:
//   ARB_DCACHE_PRIO_EN  defined   -> D-cache wins every tie (fixed priority)
//                       undefined -> round-robin on ties (default)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-low reset (0 = reset)
//   i_req      I-cache request, held with stable fields until i_ready
//   i_rw       I-cache direction: 0 = line read, 1 = line write
//   i_addr     I-cache line address
//   i_wdata    I-cache write line
//   i_rdata    I-cache read line, valid while i_ready=1, otherwise holds
//   i_ready    I-cache one-cycle completion pulse
//   d_*        same set of signals for the D-cache
//   mem_req    memory request, held until mem_ready or abort
//   mem_rw     latched direction
//   mem_addr   latched line address
//   mem_wdata  latched write line
//   mem_rdata  memory read line, valid with mem_ready
//   mem_ready  one-cycle completion pulse from memory
//   grant      current owner: 00 none, 01 I-cache, 10 D-cache
//   err        one-cycle pulse on watchdog abort (coincides with owner ready)
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 128,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic              i_rw,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [LINE_W-1:0] i_wdata,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_req,
   input  logic              d_rw,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_req,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [1:0]        grant,
   output logic              err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Final WAIT cycle value of the watchdog: the counter is 0 in the first
   // WAIT cycle, so mem_req stays high for exactly TIMEOUT cycles on abort.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state_reg;
   logic              last_grant_reg;   // 0 = I-cache, 1 = D-cache
   logic              owner_reg;        // client owning the current transfer
   logic [CNT_W-1:0]  cnt_reg;          // watchdog
   logic [1:0]        ready_reg;        // index 0 = I-cache, 1 = D-cache
   logic [LINE_W-1:0] rdata_reg [2];

   // Grant decision in IDLE: 1 selects the D-cache.
   logic pick_d;

   always_comb begin
      pick_d = 1'b0;
      if (d_req && !i_req) begin
         pick_d = 1'b1;
      end else if (d_req && i_req) begin
`ifdef ARB_DCACHE_PRIO_EN
         pick_d = 1'b1;
`else
         // Serve whoever did not own the previous transfer.
         pick_d = ~last_grant_reg;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= ST_IDLE;
         last_grant_reg <= 1'b1;        // I-cache wins the first tie
         owner_reg      <= 1'b0;
         cnt_reg        <= '0;
         ready_reg      <= '0;
         rdata_reg[0]   <= '0;
         rdata_reg[1]   <= '0;
         mem_req        <= 1'b0;
         mem_rw         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         grant          <= 2'b00;
         err            <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (i_req || d_req) begin
                  owner_reg      <= pick_d;
                  last_grant_reg <= pick_d;
                  cnt_reg        <= '0;
                  mem_req        <= 1'b1;
                  mem_rw         <= pick_d ? d_rw    : i_rw;
                  mem_addr       <= pick_d ? d_addr  : i_addr;
                  mem_wdata      <= pick_d ? d_wdata : i_wdata;
                  grant          <= pick_d ? 2'b10   : 2'b01;
                  state_reg      <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               cnt_reg <= cnt_reg + 1'b1;
               // Completion beats the watchdog when both land together.
               if (mem_ready) begin
                  mem_req              <= 1'b0;
                  rdata_reg[owner_reg] <= mem_rdata;
                  ready_reg[owner_reg] <= 1'b1;
                  state_reg            <= ST_RESP;
               end else if (cnt_reg == CNT_LAST) begin
                  mem_req              <= 1'b0;
                  err                  <= 1'b1;
                  rdata_reg[owner_reg] <= '0;
                  ready_reg[owner_reg] <= 1'b1;
                  state_reg            <= ST_RESP;
               end
            end

            ST_RESP: begin
               // The owner drops its request on this edge, so IDLE only
               // sees fresh or still-pending requests.
               ready_reg <= '0;
               err       <= 1'b0;
               grant     <= 2'b00;
               state_reg <= ST_IDLE;
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign i_ready = ready_reg[0];
   assign d_ready = ready_reg[1];
   assign i_rdata = rdata_reg[0];
   assign d_rdata = rdata_reg[1];

endmodule
